// File: rtl/avl_burst_slave_mem.sv
// avl_burst_slave_mem: Avalon-MM burst responder backed by on-chip RAM.
// Accepts burst writes and queued burst reads. Read data comes back in
// acceptance order, RD_LATENCY cycles after each command leaves the queue.
// A read accepted while the engine is idle and the queue is empty bypasses
// the queue, so its first beat is RD_LATENCY cycles after acceptance.
// Optional feature macro: AVL_SLV_BACKPRESSURE_EN (LFSR-driven avl_ready stalls).
// CMD_DEPTH must be a power of 2 and at least 2; RD_LATENCY must be at least 2.
module avl_burst_slave_mem #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 128,
    parameter int BE_W       = 16,
    parameter int SIZE_W     = 9,
    parameter int MEM_AW     = 10,
    parameter int RD_LATENCY = 4,
    parameter int CMD_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avl_burstbegin,
    input  logic [ADDR_W-1:0] avl_addr,
    input  logic              avl_write_req,
    input  logic              avl_read_req,
    input  logic [DATA_W-1:0] avl_wdata,
    input  logic [BE_W-1:0]   avl_be,
    input  logic [SIZE_W-1:0] avl_size,
    output logic              avl_ready,
    output logic              avl_rdata_valid,
    output logic [DATA_W-1:0] avl_rdata,
    output logic              busy,
    output logic              err_protocol
);
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int QAW       = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int LAT_W     = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam logic [QAW:0]     Q_FULL   = (QAW + 1)'(CMD_DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 2);

    typedef enum logic       {WIDLE, WBURST}       wstate_t;
    typedef enum logic [1:0] {RIDLE, RLAT, RDATA} rstate_t;

    logic [DATA_W-1:0] ram [MEM_DEPTH];

    // Write burst tracking
    wstate_t           wstate, wstate_nxt;
    logic [MEM_AW-1:0] wbase;
    logic [SIZE_W-1:0] wsize, wbeat;

    // Read command queue
    logic [MEM_AW-1:0] q_addr [CMD_DEPTH];
    logic [SIZE_W-1:0] q_size [CMD_DEPTH];
    logic [QAW-1:0]    q_wr_ptr, q_rd_ptr;
    logic [QAW:0]      q_count;
    logic              q_empty, q_full, q_push, q_pop;

    // Read engine
    rstate_t           rstate, rstate_nxt;
    logic [MEM_AW-1:0] rbase, rload_addr, rd_idx;
    logic [SIZE_W-1:0] rsize, rbeat, rload_size;
    logic [LAT_W-1:0]  lat_cnt;
    logic              rlast, rload;

    logic              stall, size_ok, wr_xfer, wr_first, wr_en;
    logic              rd_accept, rd_xfer, rd_bypass, err_set;
    logic [MEM_AW-1:0] wr_idx;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^avl_addr[ADDR_W-1:MEM_AW];

`ifdef AVL_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, free-running stall source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == Q_FULL);
    assign size_ok = (avl_size != '0);
    assign rlast   = (rbeat == rsize - SIZE_W'(1));
    assign rd_idx  = rbase + MEM_AW'(rbeat);
    assign wr_idx  = (wstate == WIDLE) ? avl_addr[MEM_AW-1:0] : wbase + MEM_AW'(wbeat);

    // Ready: blocked in reset, on a full queue, and for new writes while reads are outstanding
    always_comb begin
        avl_ready = 1'b1;
        if (rst) avl_ready = 1'b0;
        if (avl_read_req && q_full) avl_ready = 1'b0;
        if (avl_write_req && (wstate == WIDLE) && (!q_empty || (rstate != RIDLE))) avl_ready = 1'b0;
        if (stall) avl_ready = 1'b0;
    end

    // Transfer qualification; a simultaneous read is dropped in favour of the write
    always_comb begin
        wr_xfer    = avl_write_req && avl_ready;
        wr_first   = wr_xfer && (wstate == WIDLE);
        wr_en      = (wr_first && size_ok) || (wr_xfer && (wstate == WBURST));
        rd_accept  = avl_read_req && !avl_write_req && avl_ready && (wstate == WIDLE);
        rd_xfer    = rd_accept && size_ok;
        rd_bypass  = rd_xfer && (rstate == RIDLE) && q_empty;
        q_push     = rd_xfer && !rd_bypass;
        q_pop      = !q_empty && ((rstate == RIDLE) || ((rstate == RDATA) && rlast));
        rload      = q_pop || rd_bypass;
        rload_addr = q_pop ? q_addr[q_rd_ptr] : avl_addr[MEM_AW-1:0];
        rload_size = q_pop ? q_size[q_rd_ptr] : avl_size;
        err_set    = (avl_read_req && avl_write_req)
                  || (avl_read_req && (wstate == WBURST))
                  || ((wr_first || rd_accept) && !size_ok)
                  || ((wr_first || rd_accept) && !avl_burstbegin)
                  || (wr_xfer && (wstate == WBURST) && avl_burstbegin);
    end

    // Write FSM next state
    always_comb begin
        wstate_nxt = wstate;
        unique case (wstate)
            WIDLE:   if (wr_first && (avl_size > SIZE_W'(1))) wstate_nxt = WBURST;
            WBURST:  if (wr_xfer && (wbeat == wsize - SIZE_W'(1))) wstate_nxt = WIDLE;
            default: wstate_nxt = WIDLE;
        endcase
    end

    // Read engine FSM next state
    always_comb begin
        rstate_nxt = rstate;
        unique case (rstate)
            RIDLE:   if (rload) rstate_nxt = RLAT;
            RLAT:    if (lat_cnt == '0) rstate_nxt = RDATA;
            RDATA:   if (rlast) rstate_nxt = rload ? RLAT : RIDLE;
            default: rstate_nxt = RIDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate <= WIDLE;
            rstate <= RIDLE;
        end else begin
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
        end
    end

    // Write beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   wbeat <= '0;
        else if (wr_first)                         wbeat <= SIZE_W'(1);
        else if (wr_xfer && (wstate == WBURST))    wbeat <= wbeat + SIZE_W'(1);
    end

    // Burst base address and length captures (data only, no reset)
    always_ff @(posedge clk) begin
        if (wr_first) begin
            wbase <= avl_addr[MEM_AW-1:0];
            wsize <= avl_size;
        end
        if (rload) begin
            rbase <= rload_addr;
            rsize <= rload_size;
        end
        if (q_push) begin
            q_addr[q_wr_ptr] <= avl_addr[MEM_AW-1:0];
            q_size[q_wr_ptr] <= avl_size;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            q_count  <= '0;
        end else begin
            if (q_push) q_wr_ptr <= q_wr_ptr + QAW'(1);
            if (q_pop)  q_rd_ptr <= q_rd_ptr + QAW'(1);
            if (q_push && !q_pop)      q_count <= q_count + (QAW + 1)'(1);
            else if (!q_push && q_pop) q_count <= q_count - (QAW + 1)'(1);
        end
    end

    // Read engine latency and beat counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbeat   <= '0;
            lat_cnt <= '0;
        end else if (rload) begin
            rbeat   <= '0;
            lat_cnt <= LAT_LOAD;
        end else begin
            if ((rstate == RLAT) && (lat_cnt != '0)) lat_cnt <= lat_cnt - LAT_W'(1);
            if (rstate == RDATA) rbeat <= rbeat + SIZE_W'(1);
        end
    end

    // Byte-lane RAM write for each accepted beat
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (avl_be[i]) ram[wr_idx][8*i +: 8] <= avl_wdata[8*i +: 8];
            end
        end
    end

    // Read data return, one registered beat per RDATA cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avl_rdata_valid <= 1'b0;
            avl_rdata       <= '0;
        end else begin
            avl_rdata_valid <= (rstate == RDATA);
            if (rstate == RDATA) avl_rdata <= ram[rd_idx];
        end
    end

    // Registered busy and sticky protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            busy <= (wstate == WBURST) || !q_empty || (rstate != RIDLE);
            if (err_set) err_protocol <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avl_burst_slave_mem.sv
// tb_avl_burst_slave_mem: directed plus randomized bench for avl_burst_slave_mem.
// A word-array memory model and an expected-beat queue form the reference.
module tb_avl_burst_slave_mem;
    localparam int ADDR_W     = 26;
    localparam int DATA_W     = 128;
    localparam int BE_W       = 16;
    localparam int SIZE_W     = 9;
    localparam int MEM_AW     = 10;
    localparam int RD_LATENCY = 4;
    localparam int CMD_DEPTH  = 4;
    localparam int DEPTH      = 1 << MEM_AW;
    localparam int TCLK       = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              avl_burstbegin;
    logic [ADDR_W-1:0] avl_addr;
    logic              avl_write_req;
    logic              avl_read_req;
    logic [DATA_W-1:0] avl_wdata;
    logic [BE_W-1:0]   avl_be;
    logic [SIZE_W-1:0] avl_size;
    logic              avl_ready;
    logic              avl_rdata_valid;
    logic [DATA_W-1:0] avl_rdata;
    logic              busy;
    logic              err_protocol;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                last;
        bit                chk_lat;
        bit                first;
        time               t_acc;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] wdata_q[$];
    bit                in_burst    = 1'b0;
    bit                rel_q_empty = 1'b0;

    avl_burst_slave_mem #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .SIZE_W(SIZE_W),
        .MEM_AW(MEM_AW), .RD_LATENCY(RD_LATENCY), .CMD_DEPTH(CMD_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
        .avl_write_req(avl_write_req), .avl_read_req(avl_read_req), .avl_wdata(avl_wdata),
        .avl_be(avl_be), .avl_size(avl_size), .avl_ready(avl_ready),
        .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata), .busy(busy),
        .err_protocol(err_protocol)
    );

    always #(TCLK/2) clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every valid beat must match the next expected beat; bursts must not gap
    always @(negedge clk) begin
        beat_t e;
        if (in_burst) chk("beat_gap", avl_rdata_valid, 1);
        if (avl_rdata_valid === 1'b1) begin
            chk("unexpected_beat", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdata", avl_rdata, e.data);
                if (e.chk_lat && e.first) chk("rd_latency", $time - e.t_acc, RD_LATENCY * TCLK + TCLK / 2);
                in_burst = !e.last;
            end
        end else begin
            in_burst = 1'b0;
        end
    end

    task automatic idle_bus();
        avl_write_req  = 1'b0;
        avl_read_req   = 1'b0;
        avl_burstbegin = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int cnt);
        cnt = 0;
        #1;
        while (avl_ready !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (avl_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout observed=%b expected=1", tag, avl_ready);
            $fatal(1, "ready never asserted");
        end
    endtask

    // Write burst of wdata_q[0..size-1]; size 0 issues one dropped beat
    task automatic wr_burst(input int addr, input int size, input logic [BE_W-1:0] be, output int waited);
        int cnt;
        int idx;
        waited = 0;
        for (int n = 0; n < ((size == 0) ? 1 : size); n++) begin
            avl_write_req  = 1'b1;
            avl_read_req   = 1'b0;
            avl_burstbegin = (n == 0);
            avl_addr       = ADDR_W'(addr);
            avl_size       = SIZE_W'(size);
            avl_wdata      = wdata_q[n];
            avl_be         = be;
            wait_ready("wr", cnt);
            if (n == 0) begin
                waited      = cnt;
                rel_q_empty = (exp_q.size() == 0);
            end
            @(posedge clk);
            if (size != 0) begin
                idx = (addr + n) % DEPTH;
                for (int b = 0; b < BE_W; b++)
                    if (be[b]) model_mem[idx][8*b +: 8] = wdata_q[n][8*b +: 8];
            end
            @(negedge clk);
        end
        idle_bus();
    endtask

    // Read command; expected beats come from the memory model at acceptance
    task automatic rd_cmd(input int addr, input int size, input bit chk_lat, input bit expect_ready);
        int cnt;
        beat_t e;
        avl_read_req   = 1'b1;
        avl_write_req  = 1'b0;
        avl_burstbegin = 1'b1;
        avl_addr       = ADDR_W'(addr);
        avl_size       = SIZE_W'(size);
        if (expect_ready) begin
            #1;
            chk("rd_no_stall", avl_ready, 1);
        end
        wait_ready("rd", cnt);
        @(posedge clk);
        for (int n = 0; n < size; n++) begin
            e.data    = model_mem[(addr + n) % DEPTH];
            e.first   = (n == 0);
            e.last    = (n == size - 1);
            e.chk_lat = chk_lat;
            e.t_acc   = $time;
            exp_q.push_back(e);
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || avl_rdata_valid === 1'b1 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_idle", (exp_q.size() == 0 && busy === 1'b0), 1);
        @(negedge clk);
    endtask

    initial begin
        int w;
        int a;
        int s;
        int k;
        logic [BE_W-1:0] be;

        idle_bus();
        avl_addr  = '0;
        avl_size  = '0;
        avl_wdata = '0;
        avl_be    = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", avl_ready, 0);
        chk("reset_valid", avl_rdata_valid, 0);
        chk("reset_rdata", avl_rdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err_protocol, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_ready", avl_ready, 1);
        chk("idle_busy", busy, 0);
        @(negedge clk);

        // Preload words 0..255 with random data in one long burst
        wdata_q.delete();
        for (int n = 0; n < 256; n++) wdata_q.push_back(rand128());
        wr_burst(0, 256, '1, w);
        wait_idle();

        // Size-4 write at 0x10 with data 1..4, read back with latency check
        wdata_q = {128'd1, 128'd2, 128'd3, 128'd4};
        wr_burst(32'h10, 4, '1, w);
        rd_cmd(32'h10, 4, 1, 1);
        @(negedge clk);
        #1;
        chk("busy_during_read", busy, 1);
        wait_idle();

        // Three back-to-back reads, no stall
        rd_cmd(32'h00, 2, 0, 1);
        rd_cmd(32'h20, 2, 0, 1);
        rd_cmd(32'h40, 2, 0, 1);
        wait_idle();

        // One read in flight, four queued, the next sees a full queue
        rd_cmd(32'h80, 40, 0, 1);
        repeat (2) @(negedge clk);
        for (int n = 0; n < CMD_DEPTH; n++) rd_cmd($urandom_range(0, 255), 1, 0, 1);
        avl_read_req   = 1'b1;
        avl_burstbegin = 1'b1;
        avl_addr       = ADDR_W'(32'h50);
        avl_size       = SIZE_W'(1);
        #1;
        chk("queue_full_ready", avl_ready, 0);
        idle_bus();
        wait_idle();

        // Write issued while a read is outstanding
        wdata_q = {rand128(), rand128()};
        rd_cmd(32'h30, 3, 0, 1);
        wr_burst(32'h30, 2, '1, w);
        chk("wr_blocked_by_read", (w > 0), 1);
        chk("wr_release_after_read", rel_q_empty, 1);
        rd_cmd(32'h30, 2, 0, 0);
        wait_idle();

        // Byte enables: all ones, then zero on the lower 8 bytes only
        wdata_q = {{DATA_W{1'b1}}};
        wr_burst(32'h60, 1, '1, w);
        wdata_q = {128'd0};
        wr_burst(32'h60, 1, 16'h00FF, w);
        rd_cmd(32'h60, 1, 0, 1);
        wait_idle();

        // Address wrap at the top of the RAM
        wdata_q = {rand128(), rand128(), rand128()};
        wr_burst(DEPTH - 2, 3, '1, w);
        rd_cmd(DEPTH - 2, 3, 0, 1);
        rd_cmd(0, 1, 0, 0);
        rd_cmd(DEPTH - 1, 1, 0, 0);
        wait_idle();

        // Randomized traffic within the preloaded region
        for (int it = 0; it < 24; it++) begin
            a = $urandom_range(0, 247);
            s = $urandom_range(1, 8);
            if ($urandom_range(0, 2) == 0) begin
                wdata_q.delete();
                for (int n = 0; n < s; n++) wdata_q.push_back(rand128());
                be = BE_W'($urandom);
                wr_burst(a, s, be, w);
            end else begin
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) rd_cmd($urandom_range(0, 247), $urandom_range(1, 8), 0, 0);
            end
        end
        wait_idle();
        chk("no_false_error", err_protocol, 0);

        // Size-0 commands: flagged and dropped, no beats, RAM untouched
        wdata_q = {rand128()};
        wr_burst(32'h10, 0, '1, w);
        @(negedge clk);
        chk("size0_err", err_protocol, 1);
        rd_cmd(32'h20, 0, 0, 0);
        repeat (RD_LATENCY + 4) @(negedge clk);
        chk("size0_no_busy", busy, 0);
        rd_cmd(32'h10, 1, 0, 0);
        wait_idle();

        // Reset in the middle of a read burst
        rd_cmd(32'h00, 16, 0, 0);
        k = 0;
        while (avl_rdata_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rdata_started", avl_rdata_valid, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        in_burst = 1'b0;
        #1;
        chk("rst_valid_now", avl_rdata_valid, 0);
        chk("rst_ready_now", avl_ready, 0);
        repeat (2) @(negedge clk);
        chk("rst_err_cleared", err_protocol, 0);
        chk("rst_rdata", avl_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", avl_rdata_valid, 0);
        @(negedge clk);
        rd_cmd(32'h00, 16, 1, 1);
        rd_cmd(32'h10, 4, 0, 0);
        wait_idle();
        chk("final_err", err_protocol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
